eth_tx_arbiter: RTL

- Packet-level round-robin arbiter that shares the single 32-bit TX AXIS slave port of eth_10g between N_PORTS independent packet sources, such as packet generators, a perf probe source or a control-plane source.
- Sits in the s00_axis_aclk domain directly in front of eth_10g.
- A grant is held for one whole packet (until the tlast beat), so packets from different sources are never interleaved.
- Also provides per-port packet counters and an enable input that stops new grants without truncating a packet in flight.

---
 rtl/eth_tx_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter
// Packet-level round-robin arbiter that merges N_PORTS AXI-Stream packet
// sources onto the single 32-bit TX AXIS slave of eth_10g. A grant is held
// from the first beat of a packet until its tlast beat, so packets from
// different sources never interleave.
//
// Ports:
//   clk, reset_n          AXIS clock (s00_axis_aclk), async active-low reset
//   enable                gates new grants only; a packet in flight completes
//   s_axis_*              N_PORTS packed source streams, port i at slice i
//   m_axis_*              merged stream towards eth_10g
//   grant_id              granted port index, meaningful while busy is high
//   busy                  high while a packet is being passed (PASS state)
//   pkt_count             per-port count of completed packets, port i at slice i
//
// Handshake: a beat transfers on a rising clk edge where tvalid && tready are
// both high. The m_axis side is a pure combinational pass-through of the
// granted source, so s_axis_tready[g] mirrors m_axis_tready and every other
// source sees tready low. Sources may not withdraw tvalid once raised.
module eth_tx_arbiter #(
  parameter int N_PORTS    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              enable,
  input  logic [N_PORTS*DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [N_PORTS*DATA_WIDTH/8-1:0]   s_axis_tkeep,
  input  logic [N_PORTS-1:0]                s_axis_tvalid,
  input  logic [N_PORTS-1:0]                s_axis_tlast,
  output logic [N_PORTS-1:0]                s_axis_tready,
  output logic [DATA_WIDTH-1:0]             m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]           m_axis_tkeep,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,
  output logic [$clog2(N_PORTS)-1:0]        grant_id,
  output logic                              busy,
  output logic [N_PORTS*CNT_WIDTH-1:0]      pkt_count
);

  localparam int GW = $clog2(N_PORTS);
  localparam int KW = DATA_WIDTH / 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PASS = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic [GW-1:0]        last_q, last_d;
  logic [CNT_WIDTH-1:0] cnt_q [N_PORTS];
  logic                 pkt_done;

  logic                 pick_found;
  logic [GW-1:0]        pick_idx;
  logic [GW-1:0]        cand;

  logic [DATA_WIDTH-1:0] sel_data;
  logic [KW-1:0]         sel_keep;
  logic                  sel_valid;
  logic                  sel_last;

  // Round-robin search: start just after the last granted port and take the
  // first requester, wrapping modulo N_PORTS (works for non power-of-two N).
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= N_PORTS; k++) begin
      cand = GW'((int'(last_q) + k) % N_PORTS);
      if (!pick_found && s_axis_tvalid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Source selected by the current grant.
  always_comb begin
    sel_data  = '0;
    sel_keep  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (grant_q == GW'(i)) begin
        sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_keep  = s_axis_tkeep[i*KW +: KW];
        sel_valid = s_axis_tvalid[i];
        sel_last  = s_axis_tlast[i];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_d        = last_q;
    pkt_done      = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    case (state_q)
      ST_IDLE: begin
        if (enable && pick_found) begin
          state_d = ST_PASS;
          grant_d = pick_idx;
          last_d  = pick_idx;
        end
      end
      ST_PASS: begin
        m_axis_tdata           = sel_data;
        m_axis_tkeep           = sel_keep;
        m_axis_tvalid          = sel_valid;
        m_axis_tlast           = sel_last;
        s_axis_tready[grant_q] = m_axis_tready;
        // Grant is held through source gaps; only a tlast handshake ends it.
        if (sel_valid && m_axis_tready && sel_last) begin
          pkt_done = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      // Last grant = N_PORTS-1 gives port 0 first priority after reset.
      last_q  <= GW'(N_PORTS - 1);
      for (int i = 0; i < N_PORTS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      if (pkt_done) begin
        cnt_q[grant_q] <= cnt_q[grant_q] + 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_cnt
    assign pkt_count[gi*CNT_WIDTH +: CNT_WIDTH] = cnt_q[gi];
  end

  assign busy     = (state_q == ST_PASS);
  assign grant_id = grant_q;

endmodule
